// File: rtl/fetch_buffer_if.sv
// Bundles the fetch-bus side, the redirect and the decode-side handshake of the
// fetch buffer. The buffer itself uses the slave view; whoever drives fetch
// responses, redirects and consumes instructions uses the master view.
interface fetch_buffer_if;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_ready;

  modport master (
    output fetch_valid, fetch_addr, fetch_rdata, flush, flush_addr, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );

  modport slave (
    input  fetch_valid, fetch_addr, fetch_rdata, flush, flush_addr, instr_ready,
    output fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: queues aligned 32-bit fetch words and hands the decoder one
// instruction per handshake, either a 16-bit RVC or a full 32-bit instruction,
// stitching 32-bit instructions that straddle two fetch words. Responses whose
// address does not match the next expected word are treated as stale (e.g. left
// over from before a redirect) and dropped. Outputs depend on registered state
// only, so there is no combinational path from the fetch bus to the decoder.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic    clock,
  input  logic    reset,
  fetch_buffer_if.slave bus
);

  localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_plus1;
  logic [CNT_W-1:0] count;
  logic             offset;
  logic [31:0]      pc;
  logic [29:0]      exp_addr;

  logic [31:0] head_word;
  logic [31:0] next_word;
  logic [15:0] head_half;
  logic        is_compressed;
  logic        head_valid;
  logic        do_push;
  logic        do_pop;
  logic        free_word;
  logic        unused_bits;

  // Low address bits carry no information for word fetches / halfword PCs.
  assign unused_bits = ^{bus.fetch_addr[1:0], bus.flush_addr[0]};

  // Decode the head of the queue into the instruction currently on offer.
  always_comb begin
    rd_ptr_plus1  = rd_ptr + PTR_W'(1);
    head_word     = mem[rd_ptr];
    next_word     = mem[rd_ptr_plus1];
    head_half     = offset ? head_word[31:16] : head_word[15:0];
    is_compressed = (head_half[1:0] != 2'b11);
    head_valid    = 1'b0;
    if (count != '0) begin
      if (is_compressed || !offset)
        head_valid = 1'b1;
      else
        head_valid = (count > CNT_W'(1));
    end
  end

  // Drive the decoder-facing outputs; a NOP pattern whenever nothing is valid.
  always_comb begin
    bus.instr            = NOP_INSTR;
    bus.instr_compressed = 1'b0;
    if (head_valid) begin
      bus.instr_compressed = is_compressed;
      if (is_compressed)
        bus.instr = {16'h0000, head_half};
      else if (offset)
        bus.instr = {next_word[15:0], head_word[31:16]};
      else
        bus.instr = head_word;
    end
  end

  assign bus.instr_valid = head_valid;
  assign bus.instr_pc    = pc;
  assign bus.fetch_ready = (count < FULL_COUNT);

  // A push needs room and the expected address; a pop frees the head word
  // unless an RVC was taken from its lower half.
  always_comb begin
    do_push   = bus.fetch_valid && bus.fetch_ready && !bus.flush &&
                (bus.fetch_addr[31:2] == exp_addr);
    do_pop    = head_valid && bus.instr_ready && !bus.flush;
    free_word = do_pop && (offset || !is_compressed);
  end

  // Store accepted fetch words at the write pointer.
  always_ff @(posedge clock) begin
    if (!reset && do_push)
      mem[wr_ptr] <= bus.fetch_rdata;
  end

  // Queue bookkeeping: reset beats flush, flush beats push and pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      offset   <= RESET_PC[1];
      pc       <= RESET_PC;
      exp_addr <= RESET_PC[31:2];
    end else if (bus.flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      offset   <= bus.flush_addr[1];
      pc       <= {bus.flush_addr[31:1], 1'b0};
      exp_addr <= bus.flush_addr[31:2];
    end else begin
      if (do_push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        exp_addr <= exp_addr + 30'd1;
      end
      if (do_pop) begin
        pc <= pc + (is_compressed ? 32'd2 : 32'd4);
        if (is_compressed)
          offset <= !offset;
      end
      if (free_word)
        rd_ptr <= rd_ptr_plus1;
      count <= count + CNT_W'(do_push) - CNT_W'(free_word);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: drives a linear sequence of fetch responses,
// redirects and decode handshakes, and compares outputs against hand-derived
// values between clock edges.
module tb_fetch_buffer;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  fetch_buffer_if fb_if ();

  fetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (fb_if.slave)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic applyStimulus(input logic fv, input logic [31:0] addr,
                               input logic [31:0] data, input logic fl,
                               input logic [31:0] fl_addr, input logic rdy);
    fb_if.fetch_valid = fv;
    fb_if.fetch_addr  = addr;
    fb_if.fetch_rdata = data;
    fb_if.flush       = fl;
    fb_if.flush_addr  = fl_addr;
    fb_if.instr_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence covering the main scenarios and boundaries.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("rst_instr", fb_if.instr, 32'h0000_0013);
    checkOutput("rst_pc", fb_if.instr_pc, 32'h0);
    checkOutput("rst_cmp", {31'h0, fb_if.instr_compressed}, 32'h0);
    checkOutput("rst_ready", {31'h0, fb_if.fetch_ready}, 32'h1);

    // Two aligned 32-bit instructions streaming through
    applyStimulus(1'b1, 32'h0, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t1_valid0", {31'h0, fb_if.instr_valid}, 32'h1);
    checkOutput("t1_instr0", fb_if.instr, 32'h0000_0013);
    checkOutput("t1_pc0", fb_if.instr_pc, 32'h0);
    applyStimulus(1'b1, 32'h4, 32'h0010_0093, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t1_instr1", fb_if.instr, 32'h0010_0093);
    checkOutput("t1_pc1", fb_if.instr_pc, 32'h4);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t1_empty", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t1_nop", fb_if.instr, 32'h0000_0013);

    // RVC followed by a 32-bit instruction straddling two words
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h200, 32'h0093_4505, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t2_rvc", fb_if.instr, 32'h0000_4505);
    checkOutput("t2_rvc_pc", fb_if.instr_pc, 32'h200);
    checkOutput("t2_rvc_cmp", {31'h0, fb_if.instr_compressed}, 32'h1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t2_wait_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t2_wait_pc", fb_if.instr_pc, 32'h202);
    applyStimulus(1'b1, 32'h204, 32'hABCD_0010, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t2_split", fb_if.instr, 32'h0010_0093);
    checkOutput("t2_split_pc", fb_if.instr_pc, 32'h202);
    checkOutput("t2_split_cmp", {31'h0, fb_if.instr_compressed}, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t2_tail", fb_if.instr, 32'h0000_ABCD);
    checkOutput("t2_tail_pc", fb_if.instr_pc, 32'h206);

    // Redirect to a half-aligned PC, stale response dropped
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h102, 1'b0);
    tick();
    checkOutput("t3_flush_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t3_flush_pc", fb_if.instr_pc, 32'h102);
    applyStimulus(1'b1, 32'h40, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t3_stale_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    applyStimulus(1'b1, 32'h100, 32'h4505_0001, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t3_instr", fb_if.instr, 32'h0000_4505);
    checkOutput("t3_pc", fb_if.instr_pc, 32'h102);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t3_drained", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t3_next_pc", fb_if.instr_pc, 32'h104);

    // Fill to DEPTH, back-pressure, then drain in order
    applyStimulus(1'b1, 32'h104, 32'h0010_0093, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h108, 32'h0020_0113, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h10C, 32'h0030_0193, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t4_ready3", {31'h0, fb_if.fetch_ready}, 32'h1);
    applyStimulus(1'b1, 32'h110, 32'h0040_0213, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t4_full", {31'h0, fb_if.fetch_ready}, 32'h0);
    applyStimulus(1'b1, 32'h114, 32'h0050_0293, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t4_held", {31'h0, fb_if.fetch_ready}, 32'h0);
    checkOutput("t4_head", fb_if.instr, 32'h0010_0093);
    applyStimulus(1'b1, 32'h114, 32'h0050_0293, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("t4_freed", {31'h0, fb_if.fetch_ready}, 32'h1);
    checkOutput("t4_w1", fb_if.instr, 32'h0020_0113);
    applyStimulus(1'b1, 32'h114, 32'h0050_0293, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t4_refull", {31'h0, fb_if.fetch_ready}, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_d1", fb_if.instr, 32'h0020_0113);
    checkOutput("t4_d1_pc", fb_if.instr_pc, 32'h108);
    tick();
    checkOutput("t4_d2", fb_if.instr, 32'h0030_0193);
    tick();
    checkOutput("t4_d3", fb_if.instr, 32'h0040_0213);
    tick();
    checkOutput("t4_d4", fb_if.instr, 32'h0050_0293);
    checkOutput("t4_d4_pc", fb_if.instr_pc, 32'h114);
    tick();
    checkOutput("t4_empty", {31'h0, fb_if.instr_valid}, 32'h0);

    // Flush together with push and pop: flush wins
    applyStimulus(1'b1, 32'h118, 32'h0060_0313, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h11C, 32'h0070_0393, 1'b1, 32'h300, 1'b1);
    tick();
    checkOutput("t5_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t5_nop", fb_if.instr, 32'h0000_0013);
    checkOutput("t5_pc", fb_if.instr_pc, 32'h300);
    checkOutput("t5_ready", {31'h0, fb_if.fetch_ready}, 32'h1);
    applyStimulus(1'b1, 32'h300, 32'h0080_0413, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t5_restart", fb_if.instr, 32'h0080_0413);

    // Reset in the middle of a stream with three words queued
    applyStimulus(1'b1, 32'h304, 32'h0090_0493, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h308, 32'h00A0_0513, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("t6_pre_valid", {31'h0, fb_if.instr_valid}, 32'h1);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h30C, 32'h00B0_0593, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_valid", {31'h0, fb_if.instr_valid}, 32'h0);
    checkOutput("t6_pc", fb_if.instr_pc, 32'h0);
    checkOutput("t6_ready", {31'h0, fb_if.fetch_ready}, 32'h1);
    checkOutput("t6_nop", fb_if.instr, 32'h0000_0013);
    tick();
    checkOutput("t6_still_empty", {31'h0, fb_if.instr_valid}, 32'h0);

    // PC and expected-address wrap across the top of the address space
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h0093_0000, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0, 32'h4505_0010, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("wrap_instr", fb_if.instr, 32'h0010_0093);
    checkOutput("wrap_pc", fb_if.instr_pc, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("wrap_next", fb_if.instr, 32'h0000_4505);
    checkOutput("wrap_next_pc", fb_if.instr_pc, 32'h2);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
